rtc_access_scheduler: RTL



---
 rtl/rtc_access_scheduler.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/rtc_access_scheduler.sv
// Purpose : arbitrates emulated clock-port reads/writes and a periodic background poll onto one RTC controller handshake.
// Latency : request seen in IDLE -> strobe high next cycle; rtc_ack -> emu_done next cycle; GAP forces >= 2 strobe-low cycles between accesses.
// Backpres: requests are levels held until emu_done; a missing rtc_ack is abandoned after TIMEOUT cycles, so the requester is never stalled forever.
//
// Ports:
//   clk14, reset_n            14 MHz clock, synchronous active-low reset
//   poll_enable               enables the background poll timer
//   emu_read_req/write_req    level requests from the clock-port emulation
//   emu_done, emu_error       one-cycle completion pulse, error = finished by timeout
//   rtc_read, rtc_write       level strobes to the RTC controller
//   rtc_ack                   one-cycle completion pulse from the RTC controller
//   busy                      registered "not IDLE" indication (trails the FSM by one cycle)
//   timeout_err               sticky timeout flag, cleared by the next accepted rtc_ack
`timescale 1ns/1ps
module rtc_access_scheduler #(
  parameter int POLL_PERIOD = 14000000,
  parameter int TIMEOUT     = 2000000
) (
  input  logic clk14,
  input  logic reset_n,
  input  logic poll_enable,
  input  logic emu_read_req,
  input  logic emu_write_req,
  output logic emu_done,
  output logic emu_error,
  output logic rtc_read,
  output logic rtc_write,
  input  logic rtc_ack,
  output logic busy,
  output logic timeout_err
);

  localparam int PW = $clog2(POLL_PERIOD);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [PW-1:0] POLL_RELOAD = PW'(POLL_PERIOD - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EMU_WR  = 3'd1,
    EMU_RD  = 3'd2,
    POLL_RD = 3'd3,
    GAP     = 3'd4
  } state_t;

  state_t        state;
  logic [PW-1:0] poll_timer;
  logic [TW-1:0] to_cnt;
  logic          poll_pending;
  logic          poll_tick;
  logic          pending_clr;

  assign poll_tick = poll_enable && (poll_timer == '0);

  // The pending poll is consumed either by starting the poll itself, or by an
  // emulation read that completed with ack: the shadow registers are fresh.
  always_comb begin
    pending_clr = 1'b0;
    if (state == IDLE && !emu_write_req && !emu_read_req && poll_pending)
      pending_clr = 1'b1;
    if (state == EMU_RD && rtc_ack)
      pending_clr = 1'b1;
  end

  always_ff @(posedge clk14) begin
    if (!reset_n) begin
      state        <= IDLE;
      rtc_read     <= 1'b0;
      rtc_write    <= 1'b0;
      emu_done     <= 1'b0;
      emu_error    <= 1'b0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
      poll_timer   <= POLL_RELOAD;
      poll_pending <= 1'b0;
      to_cnt       <= '0;
    end else begin
      emu_done  <= 1'b0;
      emu_error <= 1'b0;
      busy      <= (state != IDLE);

      if (poll_enable)
        poll_timer <= (poll_timer == '0) ? POLL_RELOAD : poll_timer - PW'(1);

      // A new tick wins over a same-cycle clear so a due poll is never lost.
      if (!poll_enable)
        poll_pending <= 1'b0;
      else if (poll_tick)
        poll_pending <= 1'b1;
      else if (pending_clr)
        poll_pending <= 1'b0;

      case (state)
        IDLE: begin
          if (emu_write_req) begin
            state     <= EMU_WR;
            rtc_write <= 1'b1;
            to_cnt    <= '0;
          end else if (emu_read_req) begin
            state    <= EMU_RD;
            rtc_read <= 1'b1;
            to_cnt   <= '0;
          end else if (poll_pending) begin
            state    <= POLL_RD;
            rtc_read <= 1'b1;
            to_cnt   <= '0;
          end
        end

        EMU_WR, EMU_RD, POLL_RD: begin
          if (rtc_ack) begin
            state       <= GAP;
            rtc_read    <= 1'b0;
            rtc_write   <= 1'b0;
            timeout_err <= 1'b0;
            if (state != POLL_RD)
              emu_done <= 1'b1;
          end else if (to_cnt == TO_LAST) begin
            // Abandon the access; the emulation gets an error completion,
            // a background poll simply retries at the next period.
            state       <= GAP;
            rtc_read    <= 1'b0;
            rtc_write   <= 1'b0;
            timeout_err <= 1'b1;
            if (state != POLL_RD) begin
              emu_done  <= 1'b1;
              emu_error <= 1'b1;
            end
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end

        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
